sobel_stream_core: RTL and testbench
====================================

# sobel_stream_core

Streaming, parametrised Sobel edge engine, successor to the memory-to-memory `sobel_full_system`. It accepts a raster-order pixel stream over a valid/ready handshake and holds two line buffers plus a 3x3 window. It emits one result per interior pixel with four selectable output modes and a per-frame cycle counter. It sits between a frame source (DMA or ROM reader) and an output sink (frame memory or display path), one frame per `start`.

## Interface
- `WIDTH`, 240, pixels per line (>= 3)
- `HEIGHT`, 240, lines per frame (>= 3)
- `PIX_W`, 8, bits per input/output pixel
- `CNT_W`, 32, width of cycle counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame (honoured only in IDLE or DONE)
- `mode`  in  2  00 = |Gx|+|Gy| saturating; 01 = threshold binary; 10 = |Gx| saturating; 11 = |Gy| saturating; sampled on `start`
- `threshold`  in  PIX_W  compare value for mode 01; sampled on `start`
- `in_valid`  in  1  source has pixel
- `in_ready`  out  1  core accepts pixel this cycle
- `in_pixel`  in  PIX_W  unsigned pixel, raster order
- `out_valid`  out  1  `out_pixel` holds a result
- `out_ready`  in  1  sink accepts result
- `out_pixel`  out  PIX_W  result for interior pixel
- `busy`  out  1  high in RUN or DRAIN
- `done`  out  1  level; high in DONE until next accepted `start`
- `total_cycles_out`  out  CNT_W  cycles spent in RUN+DRAIN for last/current frame

## Operation
- FSM states:
  - IDLE: `start` → RUN. Clears the column/row counters and `total_cycles_out`, and latches `mode`/`threshold`.
  - RUN: accepts pixels. On acceptance of pixel (HEIGHT-1, WIDTH-1) → DRAIN.
  - DRAIN: no input accepted. On the handshake of the final output → DONE.
  - DONE: `start` → RUN with the same clearing as from IDLE.
- `start` in RUN/DRAIN is ignored.
- Input handshake: `in_ready` = (state==RUN) && (!out_valid || out_ready). A pixel is accepted when `in_valid && in_ready`.
- Line buffers: two WIDTH x PIX_W arrays hold rows r-1 and r-2. The 3x3 window shifts one column per accepted pixel. Stale buffer contents never reach the output, because validity comes only from the counters.
- A pixel accepted at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1). Only completed windows load the output register, giving (WIDTH-2)*(HEIGHT-2) results per frame, in raster order.
- Arithmetic, window p[row][col], rows 0..2 top→bottom, cols 0..2 left→right:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Both signed, PIX_W+3 bits, no overflow.
  - |Gx|, |Gy| and |Gx|+|Gy| are computed unsigned at PIX_W+3 bits, then saturated to 2^PIX_W-1.
  - Mode 01: output all-ones if saturated(|Gx|+|Gy|) >= threshold, else 0.
- Output register: a single entry. It loads on a completing accept and clears `out_valid` on `out_valid && out_ready` unless reloaded in the same cycle. A simultaneous emit-and-load keeps `out_valid` high with the new value.
- Counter: increments every cycle in RUN or DRAIN and holds in IDLE/DONE. It saturates at all-ones instead of wrapping.
- Reset mid-frame aborts the frame. The FSM returns to IDLE and the next `start` begins a clean frame.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_pixel`=0.
  - `busy`=0, `done`=0, `total_cycles_out`=0.
  - State IDLE; counters 0.
- `start` at cycle t: RUN from t+1. `in_ready` can first be high at t+1.
- Latency: the result is in `out_pixel` with `out_valid`=1 the cycle after the completing input handshake.
- `done` rises the cycle after the final output handshake. `busy` falls in the same cycle.
- With `in_valid` and `out_ready` constantly high, `total_cycles_out` = WIDTH*HEIGHT + 1.
- `out_pixel` is stable while `out_valid && !out_ready`.

## Test plan
- WIDTH=HEIGHT=4, mode 00, uniform 100, no stalls → 4 outputs of 0, `done` high, `total_cycles_out`=17.
- 4x4 vertical step (cols 0,1 = 0; cols 2,3 = 10), mode 00 → four outputs of 40. Mode 10 → 40s; mode 11 → 0s.
- Same step image, mode 01 → threshold 40 gives four 255s; threshold 41 gives four 0s. Step 0/200, mode 00 → four 255s (saturation).
- 8x8 ramp, `out_ready` random 50% and `in_valid` random 50% → 36 outputs match the reference model in order. `out_pixel` is held under stall. `total_cycles_out` = 64 + 1 + stall cycles.
- Assert `rst` after 20 pixels of an 8x8 frame → all outputs at reset values. A following full frame yields 36 correct outputs.
- `start` pulsed during RUN → ignored, with counter and results unchanged. `start` in DONE → `done` drops next cycle and the counter restarts from 0.

Source files
------------

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge engine: raster pixel stream in, one result per interior pixel out.
// Two line buffers plus a sliding window; results pass through a single-entry output register.
module sobel_stream_core #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_cycles_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned GW = PIX_W + 3;
  localparam logic [PIX_W-1:0] PixMax = {PIX_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thr_q;
  logic             out_valid_q;
  logic [PIX_W-1:0] out_pixel_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PIX_W-1:0] lb1 [WIDTH];  // row r-1
  logic [PIX_W-1:0] lb2 [WIDTH];  // row r-2
  logic [PIX_W-1:0] win_q [3][2]; // two most recent window columns
  logic [PIX_W-1:0] nw [3][3];

  logic start_ok, accept, last_pix, complete, emit;

  logic [GW-1:0]    gx_pos, gx_neg, gy_pos, gy_neg, dx, dy, abs_x, abs_y, sum_xy;
  logic [PIX_W-1:0] sat_x, sat_y, sat_sum, res;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign accept   = in_valid && in_ready;
  assign last_pix = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
  assign complete = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign emit     = out_valid_q && out_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (accept && last_pix) state_d = StDrain;
      StDrain:        if (emit) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      StRun: begin
        in_ready = !out_valid_q || out_ready;
        busy     = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Window as it will look once the current pixel is shifted in.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win_q[r][0];
      nw[r][1] = win_q[r][1];
    end
    nw[0][2] = lb2[col_q];
    nw[1][2] = lb1[col_q];
    nw[2][2] = in_pixel;
  end

  always_comb begin
    gx_pos = GW'(nw[0][2]) + (GW'(nw[1][2]) << 1) + GW'(nw[2][2]);
    gx_neg = GW'(nw[0][0]) + (GW'(nw[1][0]) << 1) + GW'(nw[2][0]);
    gy_pos = GW'(nw[2][0]) + (GW'(nw[2][1]) << 1) + GW'(nw[2][2]);
    gy_neg = GW'(nw[0][0]) + (GW'(nw[0][1]) << 1) + GW'(nw[0][2]);
    dx     = gx_pos - gx_neg;
    dy     = gy_pos - gy_neg;
    abs_x  = dx[GW-1] ? GW'(0) - dx : dx;
    abs_y  = dy[GW-1] ? GW'(0) - dy : dy;
    sum_xy = abs_x + abs_y;
    sat_x   = (abs_x[GW-1:PIX_W] != '0) ? PixMax : abs_x[PIX_W-1:0];
    sat_y   = (abs_y[GW-1:PIX_W] != '0) ? PixMax : abs_y[PIX_W-1:0];
    sat_sum = (sum_xy[GW-1:PIX_W] != '0) ? PixMax : sum_xy[PIX_W-1:0];
    case (mode_q)
      2'b00:   res = sat_sum;
      2'b01:   res = (sat_sum >= thr_q) ? PixMax : '0;
      2'b10:   res = sat_x;
      default: res = sat_y;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (start_ok) begin
        col_q  <= '0;
        row_q  <= '0;
        mode_q <= mode;
        thr_q  <= threshold;
      end else if (accept) begin
        if (col_q == CW'(WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      // A load in the same cycle as an emit keeps the register full.
      if (complete) begin
        out_valid_q <= 1'b1;
        out_pixel_q <= res;
      end else if (emit) begin
        out_valid_q <= 1'b0;
      end

      if (start_ok) begin
        cnt_q <= '0;
      end else if (busy && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(0) + CNT_W'(1);
      end
    end
  end

  // Buffer contents need no reset: validity is derived from the counters only.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_q] <= lb1[col_q];
      lb1[col_q] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= nw[r][2];
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_pixel        = out_pixel_q;
  assign total_cycles_out = cnt_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Self-checking bench for sobel_stream_core (8x8 frames): expected results are queued
// when a frame is issued and a monitor compares them at every output handshake.
module tb_sobel_stream_core;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk, rst, start;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        in_valid, in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid, out_ready;
  logic [7:0]  out_pixel;
  logic        busy, done;
  logic [31:0] total_cycles_out;

  sobel_stream_core #(
    .WIDTH (W),
    .HEIGHT(H),
    .PIX_W (8),
    .CNT_W (32)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .threshold       (threshold),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pixel        (in_pixel),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pixel       (out_pixel),
    .busy            (busy),
    .done            (done),
    .total_cycles_out(total_cycles_out)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int unsigned ordy_rate = 100;
  logic [7:0]  img [W*H];
  logic [7:0]  exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int px(int r, int c);
    return int'(img[r*W+c]);
  endfunction

  // Direct convolution over the stored frame, centre (r,c).
  function automatic logic [7:0] ref_pix(int r, int c, logic [1:0] m, logic [7:0] th);
    int gx, gy, ax, ay, sx, sy, ss;
    gx = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1))
       - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
    gy = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1))
       - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    sx = (ax > 255) ? 255 : ax;
    sy = (ay > 255) ? 255 : ay;
    ss = (ax + ay > 255) ? 255 : ax + ay;
    case (m)
      2'd0:    return 8'(ss);
      2'd1:    return (ss >= int'(th)) ? 8'd255 : 8'd0;
      2'd2:    return 8'(sx);
      default: return 8'(sy);
    endcase
  endfunction

  task automatic push_model(input logic [1:0] m, input logic [7:0] th);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) exp_q.push_back(ref_pix(r, c, m, th));
  endtask

  // Step image: only centres 3 and 4 straddle the edge; v is the hand-computed value there.
  task automatic push_step(input logic [7:0] v);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) exp_q.push_back((c == 3 || c == 4) ? v : 8'd0);
  endtask

  task automatic fill_step(input logic [7:0] hi);
    for (int i = 0; i < W*H; i++) img[i] = ((i % W) >= 4) ? hi : 8'd0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r*W+c] = 8'((r*29 + c*c*4) & 255);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(99) < ordy_rate);
    end
  end

  // Monitor: compare every output handshake against the head of the queue.
  initial begin
    bit         hold_v = 0;
    logic [7:0] hold_pix = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
      end else begin
        if (hold_v && out_valid) chk("hold_stable", out_pixel, hold_pix);
        hold_v   = out_valid && !out_ready;
        hold_pix = out_pixel;
        if (out_valid && out_ready) begin
          last_hs = cyc + 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_pixel", out_pixel, e);
          end
        end
      end
    end
  end

  task automatic feed(input int n, input int unsigned vr);
    int idx = 0;
    int guard = 0;
    bit acc;
    in_valid = ($urandom_range(99) < vr);
    in_pixel = img[0];
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) idx++;
      if (idx < n) begin
        in_valid = ($urandom_range(99) < vr);
        in_pixel = img[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("pixels_accepted", idx, n);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] th, input int unsigned vr,
                           input int unsigned rr, input bit mid, input int exp_total);
    int t;
    int k;
    ordy_rate = rr;
    mode      = m;
    threshold = th;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t = cyc;
    // Scrambled after start to show mode/threshold were latched.
    mode      = ~m;
    threshold = ~th;
    chk("start_done_low", done, 0);
    chk("start_busy_high", busy, 1);
    chk("start_cnt_zero", total_cycles_out, 0);
    fork
      feed(W*H, vr);
      begin
        if (mid) begin
          repeat (10) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 3000);
    chk("done_seen", done, 1);
    chk("done_timing", cyc, last_hs);
    chk("busy_low", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("total_cycles", total_cycles_out, last_hs - t);
    if (exp_total >= 0) chk("total_cycles_nostall", total_cycles_out, exp_total);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; threshold = 8'd0;
    in_valid = 1'b0; in_pixel = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_total", total_cycles_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < W*H; i++) img[i] = 8'd100;
    push_step(8'd0);   run_frame(2'd0, 8'd0, 100, 100, 0, 65);
    fill_step(8'd10);
    push_step(8'd40);  run_frame(2'd0, 8'd0, 100, 100, 0, 65);
    push_step(8'd40);  run_frame(2'd2, 8'd0, 100, 100, 0, 65);
    push_step(8'd0);   run_frame(2'd3, 8'd0, 100, 100, 0, 65);
    push_step(8'd255); run_frame(2'd1, 8'd40, 100, 100, 0, 65);
    push_step(8'd0);   run_frame(2'd1, 8'd41, 100, 100, 0, 65);
    fill_step(8'd200);
    push_step(8'd255); run_frame(2'd0, 8'd0, 100, 100, 0, 65);

    fill_ramp();
    push_model(2'd0, 8'd0); run_frame(2'd0, 8'd0, 50, 50, 0, -1);
    push_model(2'd0, 8'd0); run_frame(2'd0, 8'd0, 100, 100, 1, 65);

    // Abort a frame with reset after 20 pixels.
    push_model(2'd0, 8'd0);
    ordy_rate = 100;
    mode = 2'd0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed(20, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_pixel", out_pixel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_total", total_cycles_out, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    push_model(2'd0, 8'd0);   run_frame(2'd0, 8'd0, 50, 50, 0, -1);
    push_model(2'd1, 8'd120); run_frame(2'd1, 8'd120, 50, 50, 0, -1);
    push_model(2'd3, 8'd0);   run_frame(2'd3, 8'd0, 60, 40, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
